// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, FSM state encoding and the linear
//                round-function helpers (xtime, mix_column, shift_rows).
//                Byte i of a 128-bit state sits at bits [127-8i -: 8],
//                column-major (FIPS-197 order).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR = 14;   // AES-256 rounds
    localparam int NB = 4;    // columns per state

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; bits [31:24] hold row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Row r is rotated left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%NB)) -: 8];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box (256-entry lookup).
//  Ports       : in_i  - input byte
//                out_o - substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = c_SBOX[11'd2047 - {in_i, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes256_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_round_engine
//  Description : Iterative AES-256 encryption core, one round per cycle,
//                one block in flight. Round keys arrive as a valid-qualified
//                stream; a low rk_valid stalls the round in progress.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input block handshake (block_in)
//                rk_valid/rk         - round key stream, keys 0..NR in order
//                out_valid/out_ready - output handshake (out_block)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_round_engine
    import aes_pkg::*;
#(
    parameter int NR = 14          // only 14 (AES-256) is supported
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_in,
    input  logic         rk_valid,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
);

    localparam logic [3:0] c_LAST = 4'(NR);

    aes_state_e   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_round;

    // SubBytes: one S-box per state byte.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (blk_q[8*i +: 8]),
            .out_o (w_sub[8*i +: 8])
        );
    end

    assign w_shift = shift_rows(w_sub);

    for (genvar c = 0; c < NB; c++) begin : g_mix
        assign w_mix[32*c +: 32] = mix_column(w_shift[32*c +: 32]);
    end

    // Round 0 is a bare AddRoundKey; the last round skips MixColumns.
    always_comb begin
        if (round_q == 4'd0) begin
            w_round = blk_q ^ rk;
        end else if (round_q == c_LAST) begin
            w_round = w_shift ^ rk;
        end else begin
            w_round = w_mix ^ rk;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        out_d   = out_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = block_in;
                    round_d = 4'd0;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rk_valid) begin
                    blk_d   = w_round;
                    round_d = round_q + 4'd1;
                    if (round_q == c_LAST) begin
                        out_d   = w_round;
                        round_d = 4'd0;
                        fsm_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign out_block = out_q;

endmodule
`default_nettype wire

// File: doc/aes256_round_engine.md
Name: aes256_round_engine

Overview:
- Iterative AES-256 encryption datapath; direct consumer of the 128-bit round-key stream produced by the key-expansion stage.
- Accepts one 128-bit input block (the CTR counter value) and applies one AES round per round-key beat.
- Returns the 128-bit ciphertext (keystream block) to the CTR XOR stage.
- One round per cycle; no pipelining across blocks; one block in flight.

Parameters:
- NR, 14, number of rounds; only 14 (AES-256) is supported; consumes NR+1 = 15 round keys per block.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  block_in is valid
- in_ready  output  1  engine can accept a block
- block_in  input  128  plaintext/counter block; bits [127:120] = state byte 0, column-major (FIPS-197 order)
- rk_valid  input  1  rk carries the next round key in sequence
- rk  input  128  round key; same byte order as block_in
- out_valid  output  1  out_block holds a finished ciphertext
- out_ready  input  1  downstream accepts out_block
- out_block  output  128  ciphertext

Behaviour:
- Reset: one clock is the only clock; reset is synchronous and active-high on rst. On reset, state goes to IDLE, the round counter goes to 0, the state register goes to 0, out_block goes to 0, out_valid goes to 0, and in_ready goes to 1 in the following cycle.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture block_in into the state register, set round = 0, go to ROUND.
  - rk_valid is ignored.
- ROUND:
  - in_ready = 0.
  - On each cycle with rk_valid = 1, apply round `round` using rk, then increment round:
    - round 0: state ^= rk (AddRoundKey only)
    - rounds 1..13: SubBytes, ShiftRows, MixColumns, AddRoundKey
    - round 14: SubBytes, ShiftRows, AddRoundKey (no MixColumns); out_block <= result; go to DONE.
  - rk_valid = 0 is a stall: state and round are held; no timeout.
- DONE:
  - out_valid = 1 and out_block is stable until out_ready = 1.
  - On out_valid && out_ready: go to IDLE and deassert out_valid next cycle.
  - out_block keeps its value after the handshake.
- Latency: with rk_valid continuously high, the block is accepted at edge 0, the 15 keys are consumed at edges 1..15, and out_valid is high after edge 15 (16 cycles accept-to-valid). Each stalled cycle adds 1.
- in_valid while busy (ROUND/DONE) has no effect; the upstream holds it.
- rst asserted mid-ROUND or in DONE:
  - The block is discarded and no out_valid pulse is produced.
  - The key-expansion stage is reset by the same rst and restarts at round key 0.
- The round counter is 4 bits wide; it never wraps because it exits at 14.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B.
- The critical path is one full round; no multi-cycle paths.

Decomposition:
- Package aes_pkg:
  - NR = 14, NB = 4, FSM state encodings (IDLE/ROUND/DONE).
  - Functions xtime, mix_column (32-bit), and shift_rows (128-bit).
  - The package is shared with the key-expansion and CTR stages.
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup, instantiated 16 times for SubBytes. The key-expansion stage reuses the same module.

Test Plan:
- FIPS-197 C.3 vector: block_in = 00112233445566778899aabbccddeeff, rk stream from key 000102…1f, rk_valid continuous.
  -> The state after round 0 is 00102030405060708090a0b0c0d0e0f0.
  -> out_block = 8ea2b7ca516745bfeafc49904b496089, with out_valid rising 16 cycles after acceptance.
- All-zero key, block_in = 0, rk_valid continuous.
  -> out_block = dc95c078a2408989ad48a21492842087.
- Stall: same C.3 stimulus with rk_valid low for 3 cycles after round 5 and 2 cycles after round 12.
  -> Identical ciphertext; out_valid delayed by exactly 5 cycles.
- Backpressure: out_ready held low for 6 cycles after out_valid.
  -> out_block stable and out_valid high throughout; in_ready stays 0; IDLE is entered the cycle after out_ready = 1.
- Reset mid-round: assert rst for 1 cycle during round 7, then rerun C.3.
  -> No out_valid before the rerun; in_ready = 1 the cycle after reset; correct ciphertext on the rerun.
- Busy input: pulse in_valid with block_in = ffff…ff during ROUND.
  -> Ignored; the in-flight C.3 result is unchanged; the next block is only accepted in IDLE.
